apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Converts single-beat CPU data-bus requests from the RISC-V core into APB3 transfers.
- Decodes the address to one-hot PSEL across peripheral slots (GPIO, UART, timer, ...) and muxes the selected slave's PRDATA/PREADY back.
- Sits directly upstream of every APB slave in the peripheral subsystem.
- One outstanding transfer at a time.

Parameters:
- NUM_SLAVES, 4, number of PSEL lines / slave slots.
- BASE_ADDR, 32'h1000_0000, start of the peripheral region.
- SLV_ADDR_BITS, 12, log2 of each slave window size (4 KB per slot).
- TIMEOUT_CYC, 255, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  bus clock.
- PRESET  in  1  reset.
- req_i  in  1  CPU transfer request; held until ready_o.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data; valid while ready_o = 1.
- ready_o  out  1  1-cycle completion pulse.
- err_o  out  1  decode miss or timeout; valid with ready_o.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES*32  flattened; slot k occupies bits [32k+31:32k].
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset values: state = IDLE; all outputs 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata_o, ready_o, err_o).
- Reset asserted mid-transfer aborts the transfer: next edge returns IDLE with all outputs 0 and no ready_o pulse.
- Decode:
  - hit = addr_i[31:SLV_ADDR_BITS+2] matches BASE_ADDR in the same bits, and idx < NUM_SLAVES.
  - idx = addr_i[SLV_ADDR_BITS +: 2] (width clog2(NUM_SLAVES)).
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - Accepts a request when req_i = 1 and ready_o = 0 (ready_o = 0 prevents re-issue in the completion cycle).
  - On a hit: latch PADDR = addr_i, PWRITE = we_i, PWDATA = wdata_i, PSEL[idx] = 1, go to SETUP.
  - On a miss: next cycle ready_o = 1, err_o = 1, rdata_o = 0; no APB activity; stay IDLE.
- SETUP: PSEL held, PENABLE = 0; unconditionally go to ACCESS with PENABLE = 1.
- ACCESS:
  - PSEL, PENABLE, PADDR, PWRITE and PWDATA stay stable until the selected PREADY is sampled high.
  - On that edge: PSEL = 0, PENABLE = 0, ready_o = 1, err_o = 0, go to IDLE.
  - rdata_o = selected PRDATA for reads, 0 for writes.
- Wait states: unlimited (unless APB_TIMEOUT_EN).
- PREADY/PRDATA of unselected slaves are ignored.
- Minimum latency, from the req_i sample edge to ready_o:
  - 3 cycles when PREADY is combinational.
  - 4 cycles against slaves with registered PREADY, e.g. GPIO.
- ready_o and err_o are exactly 1-cycle pulses.
- Requester must deassert req_i or present the next request in the cycle ready_o is high; the next accept is no earlier than the following cycle.
- Back-to-back throughput: one transfer per 4 cycles (combinational PREADY).

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle without PREADY.
  - When it reaches TIMEOUT_CYC: drop PSEL/PENABLE, pulse ready_o with err_o = 1 and rdata_o = 0, return to IDLE.
- Undefined: no counter; ACCESS waits indefinitely; err_o is asserted only on a decode miss.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] apb_state_t {IDLE, SETUP, ACCESS}.
  - APB_DW = 32, APB_AW = 32.
  - Default BASE_ADDR and slot constants: GPIO_SLOT = 1, UART_SLOT = 2, TIMER_SLOT = 3.
- Sub-module apb_addr_decoder (combinational):
  - Inputs: addr.
  - Outputs: hit, idx, psel_onehot.
  - Instantiated once in the bridge.

Test Plan:
- Write 0x0000_000F to 0x1000_1000 (GPIO slot 1, reg 0), PREADY registered -> PSEL = 4'b0010 for 3 cycles, PENABLE for the last 2, PWDATA = 0xF, ready_o on cycle 4, err_o = 0.
- Read 0x1000_1004 with slave PRDATA = 0x0000_000A, PREADY combinational -> ready_o at cycle 3, rdata_o = 0x0000_000A.
- Read 0x2000_0000 (decode miss) -> no PSEL ever high, ready_o = 1 and err_o = 1 on cycle 1, rdata_o = 0.
- Slave inserts 5 wait states -> PADDR/PWDATA/PSEL/PENABLE stable across all of them, single ready_o pulse after PREADY; a req_i held high through ready_o starts exactly one new transfer afterwards.
- PRESET asserted while in ACCESS -> next edge: PSEL = 0, PENABLE = 0, ready_o = 0, state IDLE.
- Timeout test (APB_TIMEOUT_EN, TIMEOUT_CYC = 10, slave never ready) -> ready_o = 1 and err_o = 1 after 10 ACCESS cycles, PSEL dropped.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master bridge
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    localparam logic [APB_AW-1:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

    localparam int GPIO_SLOT  = 1;
    localparam int UART_SLOT  = 2;
    localparam int TIMER_SLOT = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational peripheral-region decode to a one-hot slot select
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES    = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int                SLV_ADDR_BITS = 12,
    localparam int               IDX_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [APB_AW-1:0]     addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] psel_onehot
);

    localparam int TAG_LSB = SLV_ADDR_BITS + IDX_W;

    // Offset bits inside a slave window play no part in slot selection.
    logic unused_addr_offset;
    assign unused_addr_offset = ^addr[SLV_ADDR_BITS-1:0];

    assign idx = addr[SLV_ADDR_BITS +: IDX_W];
    assign hit = (addr[APB_AW-1:TAG_LSB] == BASE_ADDR[APB_AW-1:TAG_LSB])
              && (32'(idx) < 32'(NUM_SLAVES));

    always_comb begin
        psel_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            psel_onehot[k] = hit && (32'(idx) == 32'(k));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding CPU bus to APB3 master; optional APB_TIMEOUT_EN access watchdog
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES    = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int                SLV_ADDR_BITS = 12,
    parameter int                TIMEOUT_CYC   = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [APB_AW-1:0]            addr_i,
    input  logic [APB_DW-1:0]            wdata_i,
    output logic [APB_DW-1:0]            rdata_o,
    output logic                         ready_o,
    output logic                         err_o,
    output logic [APB_AW-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [APB_DW-1:0]            PWDATA,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*APB_DW-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    apb_state_t              state_q, state_n;
    logic [APB_AW-1:0]       paddr_n;
    logic [APB_DW-1:0]       pwdata_n, rdata_n, prdata_sel;
    logic [NUM_SLAVES-1:0]   psel_n, dec_psel;
    logic                    pwrite_n, penable_n, ready_n, err_n;
    logic                    dec_hit, pready_sel;
    logic [IDX_W-1:0]        unused_dec_idx;

`ifdef APB_TIMEOUT_EN
    logic [7:0]              cnt_q, cnt_n;
`else
    logic [7:0]              unused_timeout_cfg;
    assign unused_timeout_cfg = 8'(TIMEOUT_CYC);
`endif

    apb_addr_decoder #(
        .NUM_SLAVES    (NUM_SLAVES),
        .BASE_ADDR     (BASE_ADDR),
        .SLV_ADDR_BITS (SLV_ADDR_BITS)
    ) u_decoder (
        .addr        (addr_i),
        .hit         (dec_hit),
        .idx         (unused_dec_idx),
        .psel_onehot (dec_psel)
    );

    // Only the slot currently selected may complete the transfer or supply data.
    always_comb begin
        prdata_sel = '0;
        pready_sel = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (PSEL[k]) begin
                prdata_sel = prdata_sel | PRDATA[k*APB_DW +: APB_DW];
                pready_sel = pready_sel | PREADY[k];
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        psel_n    = PSEL;
        penable_n = PENABLE;
        paddr_n   = PADDR;
        pwrite_n  = PWRITE;
        pwdata_n  = PWDATA;
        rdata_n   = '0;
        ready_n   = 1'b0;
        err_n     = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_n     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // ready_o high means the held request was just served.
                if (req_i && !ready_o) begin
                    if (dec_hit) begin
                        paddr_n  = addr_i;
                        pwrite_n = we_i;
                        pwdata_n = wdata_i;
                        psel_n   = dec_psel;
                        state_n  = SETUP;
                    end else begin
                        ready_n = 1'b1;
                        err_n   = 1'b1;
                    end
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_n     = '0;
`endif
            end
            ACCESS: begin
                if (pready_sel) begin
                    psel_n    = '0;
                    penable_n = 1'b0;
                    ready_n   = 1'b1;
                    rdata_n   = PWRITE ? '0 : prdata_sel;
                    state_n   = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    psel_n    = '0;
                    penable_n = 1'b0;
                    ready_n   = 1'b1;
                    err_n     = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            rdata_o <= '0;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            PSEL    <= psel_n;
            PENABLE <= penable_n;
            PADDR   <= paddr_n;
            PWRITE  <= pwrite_n;
            PWDATA  <= pwdata_n;
            rdata_o <= rdata_n;
            ready_o <= ready_n;
            err_o   <= err_n;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= cnt_n;
`endif
        end
    end

endmodule
